gpo_timed_queue: RTL and testbench

GPO_TIMED_QUEUE -- requirements
Module: gpo_timed_queue

---
 rtl/gpo_pkg.sv | 36 +++
 rtl/gpo_sync_fifo.sv | 78 +++++++
 rtl/gpo_timed_queue.sv | 161 ++++++++++++++++
 tb/tb_gpo_timed_queue.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpo_pkg.sv
// gpo_pkg: shared timestamp type and head-of-queue classification
// for the timed GPO queue (TS_W, timestamp_t, head_e, head_class).
package gpo_pkg;

  localparam int TS_W = 64;

  typedef logic [TS_W-1:0] timestamp_t;

  typedef enum logic [1:0] {
    HEAD_IDLE = 2'd0,
    HEAD_WAIT = 2'd1,
    HEAD_HIT  = 2'd2,
    HEAD_LATE = 2'd3
  } head_e;

  // Plain unsigned compare: the timeline wraps with no correction,
  // so a head whose ts is numerically below the counter is late.
  function automatic head_e head_class(
    input logic       vld,
    input timestamp_t ts,
    input timestamp_t now
  );
    head_e c;
    if (!vld) begin
      c = HEAD_IDLE;
    end else if (ts == now) begin
      c = HEAD_HIT;
    end else if (ts < now) begin
      c = HEAD_LATE;
    end else begin
      c = HEAD_WAIT;
    end
    return c;
  endfunction

endpackage

// File: rtl/gpo_sync_fifo.sv
// gpo_sync_fifo: single-clock first-word-fall-through FIFO.
// Ports: clk_i, rst_i (sync, high), wr_en_i/wr_data_i, rd_en_i/rd_data_o,
// empty_o, full_o, count_o. Writes when full and reads when empty are ignored.
module gpo_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] wr_ptr_d;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_d;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          do_wr;
  logic          do_rd;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  assign do_wr = wr_en_i & ~full_o;
  assign do_rd = rd_en_i & ~empty_o;

  // Head is read straight from storage: valid the cycle after a write.
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/gpo_timed_queue.sv
// gpo_timed_queue: releases queued words onto gpo_out when their timestamp
// matches the timeline counter; late/overflow events are flagged sticky.
// Ports: CLK100MHZ, reset (sync, high), counter, gpo_in/gpo_ts/gpo_in_valid,
// gpo_in_ready, override_en/override_value, error_clear, gpo_out, fired,
// overrided, overflow_error, late_error, error_data, fifo_count.
// Build option: define GPO_LATE_FIRE_EN to also release late entries.
module gpo_timed_queue
  import gpo_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int OVR_W  = 64,
  parameter int DEPTH  = 16
) (
  input  logic                   CLK100MHZ,
  input  logic                   reset,
  input  logic [63:0]            counter,
  input  logic [DATA_W-1:0]      gpo_in,
  input  logic [63:0]            gpo_ts,
  input  logic                   gpo_in_valid,
  output logic                   gpo_in_ready,
  input  logic                   override_en,
  input  logic [OVR_W-1:0]       override_value,
  input  logic                   error_clear,
  output logic [DATA_W-1:0]      gpo_out,
  output logic                   fired,
  output logic                   overrided,
  output logic                   overflow_error,
  output logic                   late_error,
  output logic [DATA_W-1:0]      error_data,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int EW = DATA_W + TS_W;

`ifdef GPO_LATE_FIRE_EN
  localparam logic LATE_FIRE = 1'b1;
`else
  localparam logic LATE_FIRE = 1'b0;
`endif

  logic [EW-1:0]     fifo_wdata;
  logic [EW-1:0]     fifo_rdata;
  logic              fifo_empty;
  logic              fifo_full;
  timestamp_t        head_ts;
  logic [DATA_W-1:0] head_data;
  head_e             head_cls;

  logic hit;
  logic late;
  logic pop;
  logic fire;
  logic ovf;
  logic ovr_rel;

  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] buf_d;
  logic [DATA_W-1:0] err_data_q;
  logic [DATA_W-1:0] err_data_d;
  logic [OVR_W-1:0]  ovr_val_q;
  logic              ovr_en_q;
  logic              fired_q;
  logic              ovrd_q;
  logic              late_q;
  logic              late_d;
  logic              ovf_q;
  logic              ovf_d;

  assign fifo_wdata = {gpo_in, gpo_ts};

  gpo_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (CLK100MHZ),
    .rst_i     (reset),
    .wr_en_i   (gpo_in_valid),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign gpo_in_ready = ~fifo_full;

  assign head_ts   = fifo_rdata[TS_W-1:0];
  assign head_data = fifo_rdata[EW-1:TS_W];
  assign head_cls  = head_class(~fifo_empty, head_ts, counter);

  always_comb begin
    hit  = 1'b0;
    late = 1'b0;
    unique case (1'b1)
      (head_cls == HEAD_HIT):  hit  = 1'b1;
      (head_cls == HEAD_LATE): late = 1'b1;
      default: ;
    endcase
  end

  assign pop     = hit | late;
  assign fire    = hit | (late & LATE_FIRE);
  assign ovf     = gpo_in_valid & ~gpo_in_ready;
  assign ovr_rel = fire & ovr_en_q;

  always_comb begin
    buf_d = buf_q;
    if (fire) begin
      buf_d = head_data;
    end
  end

  // Error capture order: late, then overflow, then override release.
  always_comb begin
    err_data_d = err_data_q;
    if (late) begin
      err_data_d = head_data;
    end else if (ovf) begin
      err_data_d = gpo_in;
    end else if (ovr_rel) begin
      err_data_d = head_data;
    end
  end

  // A set in the same cycle as a clear leaves the flag asserted.
  assign late_d = late | (late_q & ~error_clear);
  assign ovf_d  = ovf | (ovf_q & ~error_clear);

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      buf_q      <= '0;
      err_data_q <= '0;
      ovr_val_q  <= '0;
      ovr_en_q   <= 1'b0;
      fired_q    <= 1'b0;
      ovrd_q     <= 1'b0;
      late_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      err_data_q <= err_data_d;
      ovr_val_q  <= override_value;
      ovr_en_q   <= override_en;
      fired_q    <= fire;
      ovrd_q     <= ovr_rel;
      late_q     <= late_d;
      ovf_q      <= ovf_d;
    end
  end

  assign gpo_out = ovr_en_q ? DATA_W'(ovr_val_q) : buf_q;

  assign fired          = fired_q;
  assign overrided      = ovrd_q;
  assign late_error     = late_q;
  assign overflow_error = ovf_q;
  assign error_data     = err_data_q;

endmodule

// File: tb/tb_gpo_timed_queue.sv
// tb_gpo_timed_queue: scenario tasks for gpo_timed_queue with a
// scoreboard of expected released words.
module tb_gpo_timed_queue;

  localparam int DATA_W = 128;
  localparam int OVR_W  = 64;
  localparam int DEPTH  = 16;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [63:0]       counter;
  logic [DATA_W-1:0] gpo_in;
  logic [63:0]       gpo_ts;
  logic              gpo_in_valid;
  logic              gpo_in_ready;
  logic              override_en;
  logic [OVR_W-1:0]  override_value;
  logic              error_clear;
  logic [DATA_W-1:0] gpo_out;
  logic              fired;
  logic              overrided;
  logic              overflow_error;
  logic              late_error;
  logic [DATA_W-1:0] error_data;
  logic [CW-1:0]     fifo_count;

  int n_chk = 0;
  int n_pass = 0;
  int fire_seen = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] obs_q[$];

  always #5 clk = ~clk;

  gpo_timed_queue #(
    .DATA_W (DATA_W),
    .OVR_W  (OVR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK100MHZ      (clk),
    .reset          (reset),
    .counter        (counter),
    .gpo_in         (gpo_in),
    .gpo_ts         (gpo_ts),
    .gpo_in_valid   (gpo_in_valid),
    .gpo_in_ready   (gpo_in_ready),
    .override_en    (override_en),
    .override_value (override_value),
    .error_clear    (error_clear),
    .gpo_out        (gpo_out),
    .fired          (fired),
    .overrided      (overrided),
    .overflow_error (overflow_error),
    .late_error     (late_error),
    .error_data     (error_data),
    .fifo_count     (fifo_count)
  );

  // One clock: sample 1ns after the edge, record releases, advance time.
  task automatic tick();
    @(posedge clk);
    #1;
    if (fired) begin
      obs_q.push_back(gpo_out);
      fire_seen++;
    end
    counter = counter + 64'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_chk++;
    if (fifo_count !== '0) $display("FAIL rst_count got %0d want 0", fifo_count);
    else n_pass++;
    n_chk++;
    if (gpo_in_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", gpo_in_ready);
    else n_pass++;
    n_chk++;
    if (gpo_out !== '0) $display("FAIL rst_out got %0h want 0", gpo_out);
    else n_pass++;
    n_chk++;
    if (error_data !== '0) $display("FAIL rst_edata got %0h want 0", error_data);
    else n_pass++;
    n_chk++;
    if ({fired, overrided, late_error, overflow_error} !== 4'b0)
      $display("FAIL rst_flags got %b want 0000",
               {fired, overrided, late_error, overflow_error});
    else n_pass++;
  endtask

  task automatic test_on_time();
    int fs;
    fs = fire_seen;
    counter = 64'd50;
    gpo_in = 128'hA5;
    gpo_ts = 64'd100;
    gpo_in_valid = 1'b1;
    tick();
    gpo_in_valid = 1'b0;
    exp_q.push_back(128'hA5);
    n_chk++;
    if (fifo_count !== CW'(1)) $display("FAIL ontime_count got %0d want 1", fifo_count);
    else n_pass++;
    for (int i = 0; i < 100 && counter != 64'd101; i++) tick();
    n_chk++;
    if (counter !== 64'd101) $display("FAIL ontime_bound got %0d want 101", counter);
    else n_pass++;
    n_chk++;
    if (fired !== 1'b1 || fire_seen - fs !== 1)
      $display("FAIL ontime_fired got %b/%0d want 1/1", fired, fire_seen - fs);
    else n_pass++;
    n_chk++;
    if (gpo_out !== 128'hA5) $display("FAIL ontime_out got %0h want a5", gpo_out);
    else n_pass++;
    n_chk++;
    if (late_error !== 1'b0) $display("FAIL ontime_late got %b want 0", late_error);
    else n_pass++;
  endtask

  task automatic test_late();
    counter = 64'd20;
    gpo_in = 128'h5C;
    gpo_ts = 64'd10;
    gpo_in_valid = 1'b1;
    tick();
    gpo_in_valid = 1'b0;
    tick();
    n_chk++;
    if (late_error !== 1'b1) $display("FAIL late_flag got %b want 1", late_error);
    else n_pass++;
    n_chk++;
    if (error_data !== 128'h5C) $display("FAIL late_edata got %0h want 5c", error_data);
    else n_pass++;
    n_chk++;
    if (fifo_count !== '0) $display("FAIL late_count got %0d want 0", fifo_count);
    else n_pass++;
`ifdef GPO_LATE_FIRE_EN
    exp_q.push_back(128'h5C);
    n_chk++;
    if (gpo_out !== 128'h5C || fired !== 1'b1)
      $display("FAIL late_out got %0h/%b want 5c/1", gpo_out, fired);
    else n_pass++;
`else
    n_chk++;
    if (gpo_out !== 128'hA5 || fired !== 1'b0)
      $display("FAIL late_out got %0h/%b want a5/0", gpo_out, fired);
    else n_pass++;
`endif
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    n_chk++;
    if (late_error !== 1'b0) $display("FAIL late_clear got %b want 0", late_error);
    else n_pass++;
  endtask

  task automatic test_overflow();
    counter = 64'd1000;
    for (int i = 0; i < 17; i++) begin
      gpo_in = DATA_W'(i + 1);
      gpo_ts = 64'd5000 + 64'(i);
      gpo_in_valid = 1'b1;
      tick();
      if (i == 15) begin
        n_chk++;
        if (gpo_in_ready !== 1'b0 || fifo_count !== CW'(16) || overflow_error !== 1'b0)
          $display("FAIL ovf_full got rdy=%b cnt=%0d ovf=%b want 0/16/0",
                   gpo_in_ready, fifo_count, overflow_error);
        else n_pass++;
      end
    end
    gpo_in_valid = 1'b0;
    n_chk++;
    if (overflow_error !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow_error);
    else n_pass++;
    n_chk++;
    if (error_data !== 128'd17) $display("FAIL ovf_edata got %0h want 11", error_data);
    else n_pass++;
    n_chk++;
    if (fifo_count !== CW'(16)) $display("FAIL ovf_count got %0d want 16", fifo_count);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++;
    if (fifo_count !== '0 || overflow_error !== 1'b0)
      $display("FAIL ovf_reset got %0d/%b want 0/0", fifo_count, overflow_error);
    else n_pass++;
  endtask

  task automatic test_override();
    counter = 64'd200;
    override_en = 1'b1;
    override_value = 64'h1234;
    gpo_in = 128'hBEEF;
    gpo_ts = 64'd203;
    gpo_in_valid = 1'b1;
    tick();
    gpo_in_valid = 1'b0;
    n_chk++;
    if (gpo_out !== 128'h1234) $display("FAIL ovr_out got %0h want 1234", gpo_out);
    else n_pass++;
    tick();
    tick();
    tick();
    exp_q.push_back(128'h1234);
    n_chk++;
    if (fired !== 1'b1 || overrided !== 1'b1)
      $display("FAIL ovr_pulse got %b/%b want 1/1", fired, overrided);
    else n_pass++;
    n_chk++;
    if (error_data !== 128'hBEEF) $display("FAIL ovr_edata got %0h want beef", error_data);
    else n_pass++;
    n_chk++;
    if (gpo_out !== 128'h1234) $display("FAIL ovr_hold got %0h want 1234", gpo_out);
    else n_pass++;
    override_en = 1'b0;
    tick();
    n_chk++;
    if (gpo_out !== 128'hBEEF || overrided !== 1'b0)
      $display("FAIL ovr_release got %0h/%b want beef/0", gpo_out, overrided);
    else n_pass++;
  endtask

  task automatic test_clear_priority();
    error_clear = 1'b1;
    counter = 64'd300;
    gpo_in = 128'h77;
    gpo_ts = 64'd290;
    gpo_in_valid = 1'b1;
    tick();
    gpo_in_valid = 1'b0;
    tick();
`ifdef GPO_LATE_FIRE_EN
    exp_q.push_back(128'h77);
`endif
    n_chk++;
    if (late_error !== 1'b1 || error_data !== 128'h77)
      $display("FAIL clr_setwins got %b/%0h want 1/77", late_error, error_data);
    else n_pass++;
    tick();
    error_clear = 1'b0;
    n_chk++;
    if (late_error !== 1'b0) $display("FAIL clr_next got %b want 0", late_error);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d;
    counter = 64'd400;
    for (int i = 0; i < 3; i++) begin
      gpo_in = 128'hD1 + DATA_W'(i);
      gpo_ts = 64'd700 + 64'(i);
      gpo_in_valid = 1'b1;
      tick();
      exp_q.push_back(128'hD1 + DATA_W'(i));
    end
    gpo_in_valid = 1'b0;
    counter = 64'd698;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      d = 128'hD1 + DATA_W'(i);
      n_chk++;
      if (fired !== 1'b1 || gpo_out !== d || fifo_count !== CW'(2 - i))
        $display("FAIL b2b_fire%0d got %b/%0h/%0d want 1/%0h/%0d",
                 i, fired, gpo_out, fifo_count, d, 2 - i);
      else n_pass++;
    end
    counter = 64'd800;
    for (int i = 0; i < 3; i++) begin
      gpo_in = 128'hE1 + DATA_W'(i);
      gpo_ts = 64'd900 + 64'(i);
      gpo_in_valid = 1'b1;
      tick();
    end
    gpo_in_valid = 1'b0;
    counter = 64'd1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      d = 128'hE1 + DATA_W'(i);
`ifdef GPO_LATE_FIRE_EN
      exp_q.push_back(d);
`endif
      n_chk++;
      if (late_error !== 1'b1 || error_data !== d || fifo_count !== CW'(2 - i))
        $display("FAIL drain%0d got %b/%0h/%0d want 1/%0h/%0d",
                 i, late_error, error_data, fifo_count, d, 2 - i);
      else n_pass++;
    end
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
  endtask

  task automatic test_wrap();
    int fs;
    counter = 64'hFFFF_FFFF_FFFF_FFFE;
    gpo_in = 128'h11;
    gpo_ts = 64'hFFFF_FFFF_FFFF_FFFF;
    gpo_in_valid = 1'b1;
    tick();
    gpo_in_valid = 1'b0;
    tick();
    exp_q.push_back(128'h11);
    n_chk++;
    if (fired !== 1'b1 || gpo_out !== 128'h11 || counter !== 64'd0)
      $display("FAIL wrap_fire got %b/%0h/%0h want 1/11/0", fired, gpo_out, counter);
    else n_pass++;
    counter = 64'd3;
    gpo_in = 128'h22;
    gpo_ts = 64'd1;
    gpo_in_valid = 1'b1;
    tick();
    gpo_in_valid = 1'b0;
    tick();
`ifdef GPO_LATE_FIRE_EN
    exp_q.push_back(128'h22);
`endif
    n_chk++;
    if (late_error !== 1'b1 || error_data !== 128'h22)
      $display("FAIL wrap_late got %b/%0h want 1/22", late_error, error_data);
    else n_pass++;
    gpo_in = 128'h33;
    gpo_ts = 64'hFFFF_FFFF_FFFF_FFF0;
    gpo_in_valid = 1'b1;
    tick();
    gpo_in_valid = 1'b0;
    fs = fire_seen;
    for (int i = 0; i < 10; i++) tick();
    n_chk++;
    if (fifo_count !== CW'(1) || fire_seen !== fs)
      $display("FAIL wrap_hold got %0d/%0d want 1/0", fifo_count, fire_seen - fs);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    int fs;
    counter = 64'd2000;
    for (int i = 0; i < 5; i++) begin
      gpo_in = 128'hF0 + DATA_W'(i);
      gpo_ts = 64'd2010 + 64'(i);
      gpo_in_valid = 1'b1;
      tick();
    end
    gpo_in_valid = 1'b0;
    n_chk++;
    if (fifo_count !== CW'(5)) $display("FAIL rmid_pre got %0d want 5", fifo_count);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++;
    if (fifo_count !== '0 || gpo_out !== '0 || gpo_in_ready !== 1'b1)
      $display("FAIL rmid_state got %0d/%0h/%b want 0/0/1",
               fifo_count, gpo_out, gpo_in_ready);
    else n_pass++;
    fs = fire_seen;
    for (int i = 0; i < 20; i++) tick();
    n_chk++;
    if (fire_seen !== fs || late_error !== 1'b0)
      $display("FAIL rmid_quiet got %0d/%b want 0/0", fire_seen - fs, late_error);
    else n_pass++;
  endtask

  task automatic test_scoreboard();
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] o;
    n_chk++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL sb_count got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++;
      if (o !== e) $display("FAIL sb_word got %0h want %0h", o, e);
      else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    counter = '0;
    gpo_in = '0;
    gpo_ts = '0;
    gpo_in_valid = 1'b0;
    override_en = 1'b0;
    override_value = '0;
    error_clear = 1'b0;
    test_reset();
    test_on_time();
    test_late();
    test_overflow();
    test_override();
    test_clear_priority();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_scoreboard();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
